// File: rtl/rom_serializer.sv
// Loadable WIDTH x DEPTH word memory streamed out one bit per clock, address 0..last,
// one-shot or looping. Define ROM_SERIALIZER_PARITY_EN to append an even-parity bit per word.
module rom_serializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk1,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] last,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef ROM_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  shreg, shreg_n;
    logic [CNT_W-1:0]  bitcnt, bitcnt_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic              loop_r, loop_n;
    logic [ADDR_W-1:0] last_r, last_n;
    logic              done_r, done_n;
    logic              word_end;
    logic [ADDR_W-1:0] nxt_addr;
    logic [WIDTH-1:0]  nxt_word;
`ifdef ROM_SERIALIZER_PARITY_EN
    logic              par_r, par_n;
`endif

    // Memory has no reset: clear must leave the loaded pattern intact.
    always_ff @(posedge clk1) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign nxt_addr = (addr_r == last_r) ? '0 : addr_r + 1'b1;
    assign nxt_word = mem[nxt_addr];

    always_ff @(posedge clk1 or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            addr_r <= '0;
            loop_r <= 1'b0;
            last_r <= '0;
            done_r <= 1'b0;
`ifdef ROM_SERIALIZER_PARITY_EN
            par_r  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            bitcnt <= bitcnt_n;
            addr_r <= addr_n;
            loop_r <= loop_n;
            last_r <= last_n;
            done_r <= done_n;
`ifdef ROM_SERIALIZER_PARITY_EN
            par_r  <= par_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        addr_n   = addr_r;
        loop_n   = loop_r;
        last_n   = last_r;
        done_n   = 1'b0;
        word_end = 1'b0;
`ifdef ROM_SERIALIZER_PARITY_EN
        par_n    = par_r;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = SHIFT;
                    shreg_n  = mem[0];
                    addr_n   = '0;
                    bitcnt_n = '0;
                    loop_n   = loop;
                    last_n   = last;
`ifdef ROM_SERIALIZER_PARITY_EN
                    par_n    = ^mem[0];
`endif
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_n = IDLE;
                end else begin
                    shreg_n  = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == LAST_BIT) begin
`ifdef ROM_SERIALIZER_PARITY_EN
                        state_n = PAR;
`else
                        word_end = 1'b1;
`endif
                    end
                end
            end
`ifdef ROM_SERIALIZER_PARITY_EN
            PAR: begin
                if (stop) begin
                    state_n = IDLE;
                end else begin
                    word_end = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // Next-word step shared by the SHIFT boundary and the end of PAR.
        if (word_end) begin
            bitcnt_n = '0;
            if (addr_r != last_r || loop_r) begin
                state_n = SHIFT;
                addr_n  = nxt_addr;
                shreg_n = nxt_word;
`ifdef ROM_SERIALIZER_PARITY_EN
                par_n   = ^nxt_word;
`endif
            end else begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end

    always_comb begin
        out = 1'b0;
        case (state)
            SHIFT:   out = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
`ifdef ROM_SERIALIZER_PARITY_EN
            PAR:     out = par_r;
`endif
            default: out = 1'b0;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = busy;
    assign done      = done_r;
    assign addr      = addr_r;

endmodule

// File: tb/tb_rom_serializer.sv
// Scoreboard bench for rom_serializer: LSB-first and MSB-first instances share all inputs,
// expected bits are queued at stimulus time and popped as each output cycle is sampled.
module tb_rom_serializer;
`ifdef ROM_SERIALIZER_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int WL = 8 + PW;

    typedef struct packed {
        logic       lsb;
        logic       msb;
        logic [3:0] a;
    } exp_t;

    logic       clk1, clear, wr_en, start, stop, loop;
    logic [3:0] wr_addr, last;
    logic [7:0] wr_data;
    logic       out_l, ov_l, busy_l, done_l;
    logic       out_m, ov_m, busy_m, done_m;
    logic [3:0] addr_l, addr_m;

    exp_t       sb[$];
    logic [7:0] mdl [16];
    int         checks = 0;
    int         failures = 0;

    rom_serializer #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .MSB_FIRST(0)) dut_l (
        .clk1(clk1), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop(loop), .last(last),
        .out(out_l), .out_valid(ov_l), .busy(busy_l), .done(done_l), .addr(addr_l)
    );

    rom_serializer #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .MSB_FIRST(1)) dut_m (
        .clk1(clk1), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop(loop), .last(last),
        .out(out_m), .out_valid(ov_m), .busy(busy_m), .done(done_m), .addr(addr_m)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic void push_word(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        for (int unsigned i = 0; i < 8; i++) begin
            e.lsb = d[i];
            e.msb = d[7-i];
            e.a   = a;
            sb.push_back(e);
        end
        if (PW != 0) begin
            e.lsb = ^d;
            e.msb = ^d;
            e.a   = a;
            sb.push_back(e);
        end
    endfunction

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk1);
        wr_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic test_reset;
        clear = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        wr_addr = '0; wr_data = '0; last = '0;
        #1 clear = 1'b1;
        #1;
        checks++;
        if ({out_l, ov_l, busy_l, done_l, addr_l, out_m, ov_m, busy_m, done_m, addr_m} !== 16'h0) begin
            failures++;
            $display("FAIL reset got=%b exp=0", {out_l, ov_l, busy_l, done_l, addr_l, out_m, ov_m, busy_m, done_m, addr_m});
        end
        @(negedge clk1);
        @(negedge clk1);
        clear = 1'b0;
        @(negedge clk1);
        checks++;
        if ({ov_l, busy_l, done_l, ov_m, busy_m, done_m} !== 6'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0", {ov_l, busy_l, done_l, ov_m, busy_m, done_m});
        end
    endtask

    task automatic test_single_word;
        exp_t e;
        int   n;
        write_word(4'd0, 8'h07);
        last = 4'd0; loop = 1'b0;
        push_word(4'd0, 8'h07);
        n = sb.size();
        start = 1'b1;
        @(posedge clk1); #1 start = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if ({ov_l, out_l, addr_l, done_l} !== {1'b1, e.lsb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL single_lsb c=%0d got=%b exp=%b", c, {ov_l, out_l, addr_l, done_l}, {1'b1, e.lsb, e.a, 1'b0});
            end
            checks++;
            if ({ov_m, out_m, addr_m, done_m} !== {1'b1, e.msb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL single_msb c=%0d got=%b exp=%b", c, {ov_m, out_m, addr_m, done_m}, {1'b1, e.msb, e.a, 1'b0});
            end
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, ov_l, out_l, done_m, busy_m, ov_m, out_m} !== 8'b1000_1000) begin
            failures++;
            $display("FAIL single_done got=%b exp=10001000", {done_l, busy_l, ov_l, out_l, done_m, busy_m, ov_m, out_m});
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, done_m, busy_m} !== 4'b0) begin
            failures++;
            $display("FAIL single_after got=%b exp=0000", {done_l, busy_l, done_m, busy_m});
        end
    endtask

    task automatic test_oneshot;
        exp_t e;
        int   n;
        write_word(4'd0, 8'hCC);
        write_word(4'd1, 8'hAA);
        last = 4'd1; loop = 1'b0;
        push_word(4'd0, 8'hCC);
        push_word(4'd1, 8'hAA);
        n = sb.size();
        start = 1'b1;
        @(posedge clk1); #1 start = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if ({ov_l, out_l, addr_l, done_l} !== {1'b1, e.lsb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL oneshot_lsb c=%0d got=%b exp=%b", c, {ov_l, out_l, addr_l, done_l}, {1'b1, e.lsb, e.a, 1'b0});
            end
            checks++;
            if ({ov_m, out_m, addr_m, done_m} !== {1'b1, e.msb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL oneshot_msb c=%0d got=%b exp=%b", c, {ov_m, out_m, addr_m, done_m}, {1'b1, e.msb, e.a, 1'b0});
            end
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, ov_l, out_l, done_m, busy_m, ov_m, out_m} !== 8'b1000_1000) begin
            failures++;
            $display("FAIL oneshot_done got=%b exp=10001000", {done_l, busy_l, ov_l, out_l, done_m, busy_m, ov_m, out_m});
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, done_m, busy_m} !== 4'b0) begin
            failures++;
            $display("FAIL oneshot_after got=%b exp=0000", {done_l, busy_l, done_m, busy_m});
        end
    endtask

    task automatic test_loop_stop;
        exp_t e;
        last = 4'd1; loop = 1'b1;
        push_word(4'd0, mdl[0]);
        push_word(4'd1, mdl[1]);
        push_word(4'd0, mdl[0]);
        start = 1'b1;
        @(posedge clk1); #1 start = 1'b0;
        loop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if ({ov_l, out_l, addr_l, done_l} !== {1'b1, e.lsb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL loop_lsb c=%0d got=%b exp=%b", c, {ov_l, out_l, addr_l, done_l}, {1'b1, e.lsb, e.a, 1'b0});
            end
            checks++;
            if ({ov_m, out_m, addr_m, done_m} !== {1'b1, e.msb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL loop_msb c=%0d got=%b exp=%b", c, {ov_m, out_m, addr_m, done_m}, {1'b1, e.msb, e.a, 1'b0});
            end
        end
        sb.delete();
        stop = 1'b1;
        @(posedge clk1); #1 stop = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk1);
            checks++;
            if ({done_l, busy_l, ov_l, out_l, done_m, busy_m, ov_m, out_m} !== 8'b0) begin
                failures++;
                $display("FAIL stop_idle c=%0d got=%b exp=00000000", c, {done_l, busy_l, ov_l, out_l, done_m, busy_m, ov_m, out_m});
            end
        end
    endtask

    task automatic test_write_during;
        exp_t e;
        int   n;
        last = 4'd1; loop = 1'b0;
        n = 2 * WL;
        // mem[0] is rewritten on the same edge that loads it: the old word must stream.
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h33;
        push_word(4'd0, mdl[0]);
        @(posedge clk1); #1 start = 1'b0; wr_en = 1'b0;
        mdl[0] = 8'h33;
        for (int c = 0; c < n; c++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if ({ov_l, out_l, addr_l, done_l} !== {1'b1, e.lsb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL wrdur_lsb c=%0d got=%b exp=%b", c, {ov_l, out_l, addr_l, done_l}, {1'b1, e.lsb, e.a, 1'b0});
            end
            checks++;
            if ({ov_m, out_m, addr_m, done_m} !== {1'b1, e.msb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL wrdur_msb c=%0d got=%b exp=%b", c, {ov_m, out_m, addr_m, done_m}, {1'b1, e.msb, e.a, 1'b0});
            end
            if (c == 2) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h5A;
                mdl[1] = 8'h5A;
                push_word(4'd1, 8'h5A);
            end
            if (c == 3) wr_en = 1'b0;
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, done_m, busy_m} !== 4'b1010) begin
            failures++;
            $display("FAIL wrdur_done got=%b exp=1010", {done_l, busy_l, done_m, busy_m});
        end
    endtask

    task automatic test_clear_mid;
        exp_t e;
        int   n;
        last = 4'd1; loop = 1'b0;
        start = 1'b1;
        @(posedge clk1); #1 start = 1'b0;
        repeat (3) @(negedge clk1);
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({out_l, ov_l, busy_l, done_l, addr_l, out_m, ov_m, busy_m, done_m, addr_m} !== 16'h0) begin
            failures++;
            $display("FAIL clear_async got=%b exp=0", {out_l, ov_l, busy_l, done_l, addr_l, out_m, ov_m, busy_m, done_m, addr_m});
        end
        @(negedge clk1);
        clear = 1'b0;
        @(negedge clk1);
        push_word(4'd0, mdl[0]);
        push_word(4'd1, mdl[1]);
        n = sb.size();
        start = 1'b1;
        @(posedge clk1); #1 start = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if ({ov_l, out_l, addr_l, done_l} !== {1'b1, e.lsb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL replay_lsb c=%0d got=%b exp=%b", c, {ov_l, out_l, addr_l, done_l}, {1'b1, e.lsb, e.a, 1'b0});
            end
            checks++;
            if ({ov_m, out_m, addr_m, done_m} !== {1'b1, e.msb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL replay_msb c=%0d got=%b exp=%b", c, {ov_m, out_m, addr_m, done_m}, {1'b1, e.msb, e.a, 1'b0});
            end
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, done_m, busy_m} !== 4'b1010) begin
            failures++;
            $display("FAIL replay_done got=%b exp=1010", {done_l, busy_l, done_m, busy_m});
        end
    endtask

    task automatic test_start_held;
        exp_t e;
        int   n;
        last = 4'd1; loop = 1'b0;
        push_word(4'd0, mdl[0]);
        push_word(4'd1, mdl[1]);
        n = sb.size();
        start = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if ({ov_l, out_l, addr_l, done_l} !== {1'b1, e.lsb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL held_lsb c=%0d got=%b exp=%b", c, {ov_l, out_l, addr_l, done_l}, {1'b1, e.lsb, e.a, 1'b0});
            end
            checks++;
            if ({ov_m, out_m, addr_m, done_m} !== {1'b1, e.msb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL held_msb c=%0d got=%b exp=%b", c, {ov_m, out_m, addr_m, done_m}, {1'b1, e.msb, e.a, 1'b0});
            end
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, done_m, busy_m} !== 4'b1010) begin
            failures++;
            $display("FAIL held_done got=%b exp=1010", {done_l, busy_l, done_m, busy_m});
        end
        push_word(4'd0, mdl[0]);
        push_word(4'd1, mdl[1]);
        for (int c = 0; c < n; c++) begin
            @(negedge clk1);
            e = sb.pop_front();
            checks++;
            if ({ov_l, out_l, addr_l, done_l} !== {1'b1, e.lsb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL restart_lsb c=%0d got=%b exp=%b", c, {ov_l, out_l, addr_l, done_l}, {1'b1, e.lsb, e.a, 1'b0});
            end
            checks++;
            if ({ov_m, out_m, addr_m, done_m} !== {1'b1, e.msb, e.a, 1'b0}) begin
                failures++;
                $display("FAIL restart_msb c=%0d got=%b exp=%b", c, {ov_m, out_m, addr_m, done_m}, {1'b1, e.msb, e.a, 1'b0});
            end
            if (c == 0) start = 1'b0;
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, done_m, busy_m} !== 4'b1010) begin
            failures++;
            $display("FAIL restart_done got=%b exp=1010", {done_l, busy_l, done_m, busy_m});
        end
        @(negedge clk1);
        checks++;
        if ({done_l, busy_l, done_m, busy_m} !== 4'b0) begin
            failures++;
            $display("FAIL restart_after got=%b exp=0000", {done_l, busy_l, done_m, busy_m});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_oneshot();
        test_loop_stop();
        test_write_during();
        test_clear_mid();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
